// File: rtl/ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : ctrl_pkg                                                     |
// | Description : Shared encodings for the multicycle controller: opcodes,     |
// |               FSM state enum, ALU-op codes, PC/ALU-B mux selects and the   |
// |               packed control word produced by the output decoder.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package ctrl_pkg;

   // Opcode field values (5-bit)
   localparam logic [4:0] OP_RTYPE = 5'h00;
   localparam logic [4:0] OP_LW    = 5'h01;
   localparam logic [4:0] OP_SW    = 5'h02;
   localparam logic [4:0] OP_BEQ   = 5'h03;
   localparam logic [4:0] OP_ADDI  = 5'h04;
   localparam logic [4:0] OP_J     = 5'h05;
   localparam logic [4:0] OP_BNE   = 5'h06;
   localparam logic [4:0] OP_HALT  = 5'h1F;

   // ALU decoder commands
   localparam logic [3:0] ALUOP_ADD   = 4'b0000;
   localparam logic [3:0] ALUOP_SUB   = 4'b0001;
   localparam logic [3:0] ALUOP_FUNCT = 4'b0010;

   // PC source mux
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // ALU B source mux
   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_ADDIEX = 4'd8,
      S_ADDIWB = 4'd9,
      S_BRANCH = 4'd10,
      S_JUMP   = 4'd11,
      S_STOP   = 4'd12
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       memread;
      logic       memwrite;
      logic       iord;
      logic       irwrite;
      logic       pcen;
      logic [1:0] pcsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [3:0] aluop;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       instr_done;
      logic       halted;
   } ctrl_t;

   // State entered after DECODE for a given opcode; anything unknown halts.
   function automatic state_t decode_target(input logic [4:0] op);
      case (op)
         OP_LW, OP_SW:   decode_target = S_MEMADR;
         OP_RTYPE:       decode_target = S_EXEC;
         OP_ADDI:        decode_target = S_ADDIEX;
         OP_BEQ, OP_BNE: decode_target = S_BRANCH;
         OP_J:           decode_target = S_JUMP;
         default:        decode_target = S_STOP;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mc_outdec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mc_outdec                                                    |
// | Description : Combinational control-word decode for the multicycle         |
// |               controller. Mostly a Moore decode of the state; FETCH,       |
// |               MEMWR and BRANCH additionally look at mem_ready / zero.      |
// | Ports       : i_state     current FSM state                                |
// |               i_zero      ALU zero flag                                    |
// |               i_mem_ready shared memory completed this cycle               |
// |               i_bne       branch in flight is BNE (else BEQ)               |
// |               o_ctrl      full datapath control word                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mc_outdec
   import ctrl_pkg::*;
(
   input  state_t i_state,
   input  logic   i_zero,
   input  logic   i_mem_ready,
   input  logic   i_bne,
   output ctrl_t  o_ctrl
);

   logic w_pcwrite;
   logic w_branch;
   logic w_cond;

   // BEQ takes the branch on zero, BNE on not-zero.
   assign w_cond = i_bne ? ~i_zero : i_zero;

   always_comb begin
      o_ctrl    = '0;
      w_pcwrite = 1'b0;
      w_branch  = 1'b0;
      case (i_state)
         S_FETCH: begin
            o_ctrl.mem_req = 1'b1;
            o_ctrl.memread = 1'b1;
            o_ctrl.alusrcb = SRCB_FOUR;
            o_ctrl.aluop   = ALUOP_ADD;
            o_ctrl.pcsrc   = PCSRC_ALU;
            // IR load and PC+4 only happen once the fetch actually returns.
            if (i_mem_ready) begin
               o_ctrl.irwrite = 1'b1;
               w_pcwrite      = 1'b1;
            end
         end
         S_DECODE: begin
            // Branch target precomputed into ALUOut while decoding.
            o_ctrl.alusrcb = SRCB_IMM;
            o_ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMADR: begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = SRCB_IMM;
            o_ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMRD: begin
            o_ctrl.mem_req = 1'b1;
            o_ctrl.memread = 1'b1;
            o_ctrl.iord    = 1'b1;
         end
         S_MEMWB: begin
            o_ctrl.regwrite   = 1'b1;
            o_ctrl.memtoreg   = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         S_MEMWR: begin
            o_ctrl.mem_req    = 1'b1;
            o_ctrl.memwrite   = 1'b1;
            o_ctrl.iord       = 1'b1;
            o_ctrl.instr_done = i_mem_ready;
         end
         S_EXEC: begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = SRCB_B;
            o_ctrl.aluop   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            o_ctrl.regwrite   = 1'b1;
            o_ctrl.regdst     = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         S_ADDIEX: begin
            o_ctrl.alusrca = 1'b1;
            o_ctrl.alusrcb = SRCB_IMM;
            o_ctrl.aluop   = ALUOP_ADD;
         end
         S_ADDIWB: begin
            o_ctrl.regwrite   = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         S_BRANCH: begin
            o_ctrl.alusrca    = 1'b1;
            o_ctrl.alusrcb    = SRCB_B;
            o_ctrl.aluop      = ALUOP_SUB;
            o_ctrl.pcsrc      = PCSRC_ALUOUT;
            w_branch          = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         S_JUMP: begin
            o_ctrl.pcsrc      = PCSRC_JUMP;
            w_pcwrite         = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         S_STOP: begin
            o_ctrl.halted = 1'b1;
         end
         default: ;
      endcase
      o_ctrl.pcen = w_pcwrite | (w_branch & w_cond);
   end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_controller                                        |
// | Description : Multicycle control FSM for the 5-bit-opcode CPU. Sequences   |
// |               fetch/decode/execute/memory/writeback over a shared memory   |
// |               and ALU, stalls on mem_ready, halts on HALT/illegal opcode.  |
// | Ports       : clk, reset_n (async active-low)                              |
// |               op, zero, mem_ready                       -- inputs          |
// |               mem_req, memread, memwrite, iord, irwrite, pcen, pcsrc,      |
// |               alusrca, alusrcb, aluop, regdst, memtoreg, regwrite,         |
// |               instr_done, halted                        -- control outputs |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module multicycle_controller
   import ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [4:0] op,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       memread,
   output logic       memwrite,
   output logic       iord,
   output logic       irwrite,
   output logic       pcen,
   output logic [1:0] pcsrc,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [3:0] aluop,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       instr_done,
   output logic       halted
);

   state_t r_state;
   state_t w_next;
   logic   r_bne;
   ctrl_t  w_ctrl;

   // op is only trusted in DECODE, so the BEQ/BNE distinction needed in
   // BRANCH is captured there rather than re-read from the live opcode.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_FETCH;
         r_bne   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_bne <= (op == OP_BNE);
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: w_next = decode_target(op);
         S_MEMADR: w_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  w_next = mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWB:  w_next = S_FETCH;
         S_MEMWR:  w_next = mem_ready ? S_FETCH : S_MEMWR;
         S_EXEC:   w_next = S_ALUWB;
         S_ALUWB:  w_next = S_FETCH;
         S_ADDIEX: w_next = S_ADDIWB;
         S_ADDIWB: w_next = S_FETCH;
         S_BRANCH: w_next = S_FETCH;
         S_JUMP:   w_next = S_FETCH;
         S_STOP:   w_next = S_STOP;
         default:  w_next = S_FETCH;
      endcase
   end

   mc_outdec u_outdec (
      .i_state     (r_state),
      .i_zero      (zero),
      .i_mem_ready (mem_ready),
      .i_bne       (r_bne),
      .o_ctrl      (w_ctrl)
   );

   assign mem_req    = w_ctrl.mem_req;
   assign memread    = w_ctrl.memread;
   assign memwrite   = w_ctrl.memwrite;
   assign iord       = w_ctrl.iord;
   assign irwrite    = w_ctrl.irwrite;
   assign pcen       = w_ctrl.pcen;
   assign pcsrc      = w_ctrl.pcsrc;
   assign alusrca    = w_ctrl.alusrca;
   assign alusrcb    = w_ctrl.alusrcb;
   assign aluop      = w_ctrl.aluop;
   assign regdst     = w_ctrl.regdst;
   assign memtoreg   = w_ctrl.memtoreg;
   assign regwrite   = w_ctrl.regwrite;
   assign instr_done = w_ctrl.instr_done;
   assign halted     = w_ctrl.halted;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multicycle_controller                                     |
// | Description : Directed self-checking bench for multicycle_controller.      |
// |               Compares the full 20-bit control word every cycle against    |
// |               hand-derived per-state values.                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_multicycle_controller;

   // Control word layout:
   // mem_req memread memwrite iord irwrite pcen pcsrc[2] alusrca alusrcb[2]
   // aluop[4] regdst memtoreg regwrite instr_done halted
   localparam logic [19:0] C_FETCH_WAIT = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b01,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_FETCH_RDY  = {1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,2'b00,1'b0,2'b01,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b10,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_MEMADR     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_MEMRD      = {1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_MEMWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,4'b0000,1'b0,1'b1,1'b1,1'b1,1'b0};
   localparam logic [19:0] C_MEMWR_WAIT = {1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_MEMWR_RDY  = {1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b0,1'b1,1'b0};
   localparam logic [19:0] C_EXEC       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b00,4'b0010,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_ALUWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,4'b0000,1'b1,1'b0,1'b1,1'b1,1'b0};
   localparam logic [19:0] C_ADDIEX     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,2'b10,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b0};
   localparam logic [19:0] C_ADDIWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b1,1'b1,1'b0};
   localparam logic [19:0] C_BR_TAKEN   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b1,2'b00,4'b0001,1'b0,1'b0,1'b0,1'b1,1'b0};
   localparam logic [19:0] C_BR_NOT     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,2'b00,4'b0001,1'b0,1'b0,1'b0,1'b1,1'b0};
   localparam logic [19:0] C_JUMP       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b0,1'b1,1'b0};
   localparam logic [19:0] C_STOP       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,4'b0000,1'b0,1'b0,1'b0,1'b0,1'b1};

   localparam logic [4:0] OP_RTYPE = 5'h00;
   localparam logic [4:0] OP_LW    = 5'h01;
   localparam logic [4:0] OP_SW    = 5'h02;
   localparam logic [4:0] OP_BEQ   = 5'h03;
   localparam logic [4:0] OP_ADDI  = 5'h04;
   localparam logic [4:0] OP_J     = 5'h05;
   localparam logic [4:0] OP_BNE   = 5'h06;
   localparam logic [4:0] OP_ILL   = 5'h0A;
   localparam logic [4:0] OP_HALT  = 5'h1F;

   logic       clk;
   logic       reset_n;
   logic [4:0] op;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, memread, memwrite, iord, irwrite, pcen;
   logic [1:0] pcsrc;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [3:0] aluop;
   logic       regdst, memtoreg, regwrite, instr_done, halted;
   logic [19:0] ctl;

   int n_checks = 0;
   int n_fail   = 0;

   multicycle_controller dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .op         (op),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .memread    (memread),
      .memwrite   (memwrite),
      .iord       (iord),
      .irwrite    (irwrite),
      .pcen       (pcen),
      .pcsrc      (pcsrc),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .aluop      (aluop),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .instr_done (instr_done),
      .halted     (halted)
   );

   assign ctl = {mem_req, memread, memwrite, iord, irwrite, pcen, pcsrc, alusrca,
                 alusrcb, aluop, regdst, memtoreg, regwrite, instr_done, halted};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Each task is entered and left at posedge+1 with the DUT sitting in FETCH.

   task automatic test_reset();
      reset_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; op = OP_LW;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (ctl !== C_FETCH_WAIT) begin
         n_fail++; $display("FAIL reset_hold: got %h expected %h", ctl, C_FETCH_WAIT);
      end
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (ctl !== C_FETCH_WAIT) begin
         n_fail++; $display("FAIL reset_release: got %h expected %h", ctl, C_FETCH_WAIT);
      end
      // Walk an LW into a stalled MEMRD, then reset asynchronously.
      mem_ready = 1'b1;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++;
      if (ctl !== C_MEMRD) begin
         n_fail++; $display("FAIL reset_memrd_entry: got %h expected %h", ctl, C_MEMRD);
      end
      @(posedge clk); #1;
      n_checks++;
      if (ctl !== C_MEMRD) begin
         n_fail++; $display("FAIL reset_memrd_stall: got %h expected %h", ctl, C_MEMRD);
      end
      #2; reset_n = 1'b0;
      #1;
      n_checks++;
      if (ctl !== C_FETCH_WAIT) begin
         n_fail++; $display("FAIL reset_async_midinstr: got %h expected %h", ctl, C_FETCH_WAIT);
      end
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (ctl !== C_FETCH_WAIT) begin
         n_fail++; $display("FAIL reset_refetch: got %h expected %h", ctl, C_FETCH_WAIT);
      end
   endtask

   task automatic test_lw();
      logic [19:0] tbl [5];
      logic [4:0]  opv [5];
      tbl = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB};
      // op disturbed in MEMRD/MEMWB must not matter.
      opv = '{OP_LW, OP_LW, OP_LW, OP_SW, OP_J};
      for (int i = 0; i < 5; i++) begin
         op = opv[i]; mem_ready = 1'b1; zero = 1'b0;
         #1;
         n_checks++;
         if (ctl !== tbl[i]) begin
            n_fail++; $display("FAIL lw cycle %0d: got %h expected %h", i + 1, ctl, tbl[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_sw_stall();
      logic [19:0] tbl [7];
      logic        mr  [7];
      tbl = '{C_FETCH_RDY, C_DECODE, C_MEMADR, C_MEMWR_WAIT, C_MEMWR_WAIT, C_MEMWR_WAIT, C_MEMWR_RDY};
      // mem_ready low in DECODE/MEMADR is ignored; low 3 cycles in MEMWR stalls.
      mr  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      op = OP_SW;
      for (int i = 0; i < 7; i++) begin
         mem_ready = mr[i];
         #1;
         n_checks++;
         if (ctl !== tbl[i]) begin
            n_fail++; $display("FAIL sw_stall cycle %0d: got %h expected %h", i + 1, ctl, tbl[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      logic [19:0] tbl [12];
      logic [4:0]  opv [12];
      logic        zv  [12];
      tbl = '{C_FETCH_RDY, C_DECODE, C_BR_TAKEN,
              C_FETCH_RDY, C_DECODE, C_BR_NOT,
              C_FETCH_RDY, C_DECODE, C_BR_TAKEN,
              C_FETCH_RDY, C_DECODE, C_BR_NOT};
      // BRANCH-cycle op swapped to the other branch: must be ignored.
      opv = '{OP_BEQ, OP_BEQ, OP_BNE,
              OP_BNE, OP_BNE, OP_BEQ,
              OP_BNE, OP_BNE, OP_BEQ,
              OP_BEQ, OP_BEQ, OP_BNE};
      zv  = '{1'b0, 1'b0, 1'b1,
              1'b0, 1'b0, 1'b1,
              1'b1, 1'b1, 1'b0,
              1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 12; i++) begin
         op = opv[i]; zero = zv[i]; mem_ready = 1'b1;
         #1;
         n_checks++;
         if (ctl !== tbl[i]) begin
            n_fail++; $display("FAIL branch cycle %0d: got %h expected %h", i + 1, ctl, tbl[i]);
         end
         @(posedge clk); #1;
      end
      zero = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [19:0] tbl [11];
      logic [4:0]  opv [11];
      tbl = '{C_FETCH_RDY, C_DECODE, C_EXEC, C_ALUWB,
              C_FETCH_RDY, C_DECODE, C_ADDIEX, C_ADDIWB,
              C_FETCH_RDY, C_DECODE, C_JUMP};
      opv = '{OP_RTYPE, OP_RTYPE, OP_LW, OP_LW,
              OP_ADDI, OP_ADDI, OP_SW, OP_HALT,
              OP_J, OP_J, OP_ILL};
      for (int i = 0; i < 11; i++) begin
         op = opv[i]; mem_ready = 1'b1;
         #1;
         n_checks++;
         if (ctl !== tbl[i]) begin
            n_fail++; $display("FAIL back_to_back cycle %0d: got %h expected %h", i + 1, ctl, tbl[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_halt(input logic [4:0] hop, input string name);
      logic [19:0] tbl [6];
      logic [4:0]  opv [6];
      tbl = '{C_FETCH_RDY, C_DECODE, C_STOP, C_STOP, C_STOP, C_STOP};
      opv = '{hop, hop, OP_LW, OP_J, OP_RTYPE, OP_SW};
      for (int i = 0; i < 6; i++) begin
         op = opv[i]; mem_ready = 1'b1;
         #1;
         n_checks++;
         if (ctl !== tbl[i]) begin
            n_fail++; $display("FAIL %s cycle %0d: got %h expected %h", name, i + 1, ctl, tbl[i]);
         end
         @(posedge clk); #1;
      end
      // Only reset leaves STOP.
      mem_ready = 1'b0;
      #1; reset_n = 1'b0;
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (ctl !== C_FETCH_WAIT) begin
         n_fail++; $display("FAIL %s after_reset: got %h expected %h", name, ctl, C_FETCH_WAIT);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_sw_stall();
      test_branch();
      test_back_to_back();
      test_halt(OP_ILL, "illegal");
      test_halt(OP_HALT, "halt");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
